// File: rtl/esop_tt_sweeper.sv
// esop_tt_sweeper: sweeps every input vector into a combinational ESOP
// netlist, samples its single output, and streams the resulting truth table
// as WORD_W-bit words over a valid/ready interface.
// Optional feature macro: ESOP_SWEEP_SIG_EN adds a rotate-xor signature
// output (sig_o) over all accepted words.
module esop_tt_sweeper #(
  parameter int NIN      = 8,
  parameter int WORD_W   = 32,
  parameter int EVAL_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [NIN-1:0]    x_o,
  input  logic              y_i,
  output logic [WORD_W-1:0] word_data,
  output logic [NIN-1:0]    word_idx,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [NIN:0]      ones_cnt
`ifdef ESOP_SWEEP_SIG_EN
  ,
  output logic [WORD_W-1:0] sig_o
`endif
);

  localparam int WB     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int LB     = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
  localparam int NWORDS = (1 << NIN) / WORD_W;

  localparam logic [WB-1:0]  LAST_SLOT = WB'(WORD_W - 1);
  localparam logic [NIN-1:0] LAST_WORD = NIN'(NWORDS - 1);
  localparam logic [LB-1:0]  LAST_LAT  = LB'(EVAL_LAT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EMIT, FIN} state_t;

  state_t         state;
  logic [NIN-1:0] vec;       // vector being presented while in ISSUE
  logic [LB-1:0]  lat_cnt;   // cycles spent in DRAIN
  logic           samp_valid;
  logic [WB-1:0]  samp_idx;

  // Sequencer, sample capture and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in
    // this block sees pre-edge values, independent of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      x_o        <= '0;
      vec        <= '0;
      lat_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_idx   <= '0;
      ones_cnt   <= '0;
`ifdef ESOP_SWEEP_SIG_EN
      sig_o      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          vec      <= '0;
          word_idx <= '0;
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            x_o       <= '0;
            ones_cnt  <= '0;
            word_data <= '0;
`ifdef ESOP_SWEEP_SIG_EN
            sig_o     <= '0;
`endif
          end
        end
        ISSUE: begin
          vec <= vec + 1'b1;
          if (vec[WB-1:0] == LAST_SLOT) begin
            // Last vector of this word stays on x_o while the netlist drains.
            lat_cnt    <= '0;
            state      <= (EVAL_LAT == 0) ? EMIT : DRAIN;
            word_valid <= (EVAL_LAT == 0);
          end else begin
            x_o <= vec + 1'b1;
          end
        end
        DRAIN: begin
          if (lat_cnt == LAST_LAT) begin
            state      <= EMIT;
            word_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        EMIT: begin
          if (word_ready) begin
            word_valid <= 1'b0;
`ifdef ESOP_SWEEP_SIG_EN
            sig_o <= {sig_o[WORD_W-2:0], sig_o[WORD_W-1]} ^ word_data;
`endif
            if (word_idx == LAST_WORD) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              word_idx  <= word_idx + 1'b1;
              word_data <= '0;
              x_o       <= vec;
              state     <= ISSUE;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // Samples only arrive in ISSUE/DRAIN, never alongside the clears above.
      if (samp_valid) begin
        word_data[samp_idx] <= y_i;
        ones_cnt            <= ones_cnt + (NIN+1)'(y_i);
      end
    end
  end

  generate
    if (EVAL_LAT == 0) begin : g_comb
      assign samp_valid = (state == ISSUE);
      assign samp_idx   = vec[WB-1:0];
    end else begin : g_pipe
      logic [EVAL_LAT-1:0] dv;
      logic [WB-1:0]       didx [EVAL_LAT];

      // Sample-valid delay line; reset so in-flight vectors are discarded.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dv <= '0;
        end else begin
          dv[0] <= (state == ISSUE);
          for (int i = 1; i < EVAL_LAT; i++) dv[i] <= dv[i-1];
        end
      end

      // Bit-slot delay line travelling alongside the valid flags.
      always_ff @(posedge clk) begin
        // NOTE: no reset on this array; its contents are ignored unless the
        // matching valid flag is set, and that flag is reset.
        didx[0] <= vec[WB-1:0];
        for (int i = 1; i < EVAL_LAT; i++) didx[i] <= didx[i-1];
      end

      assign samp_valid = dv[EVAL_LAT-1];
      assign samp_idx   = didx[EVAL_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_esop_tt_sweeper.sv
// Self-checking bench for esop_tt_sweeper: two instances (EVAL_LAT=0 and 2)
// drive a truth-table-defined netlist; expected words, counts and latencies
// come from the table itself.
module tb_esop_tt_sweeper;

  localparam int NIN    = 8;
  localparam int WORD_W = 32;
  localparam int NWORDS = (1 << NIN) / WORD_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, start_b, word_ready, sel;
  logic [255:0] tt;   // netlist function: y = tt[x]

  logic              busy_a, done_a, wv_a, busy_b, done_b, wv_b, y_a, y_b;
  logic [NIN-1:0]    x_a, wi_a, x_b, wi_b, xb_d1, xb_d2;
  logic [WORD_W-1:0] wd_a, wd_b;
  logic [NIN:0]      ones_a, ones_b;
`ifdef ESOP_SWEEP_SIG_EN
  logic [WORD_W-1:0] sig_a, sig_b, m_sig;
`endif

  logic              m_busy, m_done, m_valid;
  logic [NIN-1:0]    m_x, m_idx;
  logic [WORD_W-1:0] m_data;
  logic [NIN:0]      m_ones;

  int n_checks = 0;
  int n_fail   = 0;

  assign y_a = tt[x_a];
  assign y_b = tt[xb_d2];

  // Two register stages between DUT B and the netlist.
  always @(posedge clk) begin
    xb_d1 <= x_b;
    xb_d2 <= xb_d1;
  end

  esop_tt_sweeper #(.NIN(NIN), .WORD_W(WORD_W), .EVAL_LAT(0)) dut_a (
`ifdef ESOP_SWEEP_SIG_EN
    .sig_o(sig_a),
`endif
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .x_o(x_a), .y_i(y_a), .word_data(wd_a), .word_idx(wi_a),
    .word_valid(wv_a), .word_ready(word_ready), .ones_cnt(ones_a)
  );

  esop_tt_sweeper #(.NIN(NIN), .WORD_W(WORD_W), .EVAL_LAT(2)) dut_b (
`ifdef ESOP_SWEEP_SIG_EN
    .sig_o(sig_b),
`endif
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .x_o(x_b), .y_i(y_b), .word_data(wd_b), .word_idx(wi_b),
    .word_valid(wv_b), .word_ready(word_ready), .ones_cnt(ones_b)
  );

  // Observe the instance under test.
  always_comb begin
    m_busy  = sel ? busy_b : busy_a;
    m_done  = sel ? done_b : done_a;
    m_valid = sel ? wv_b   : wv_a;
    m_x     = sel ? x_b    : x_a;
    m_idx   = sel ? wi_b   : wi_a;
    m_data  = sel ? wd_b   : wd_a;
    m_ones  = sel ? ones_b : ones_a;
`ifdef ESOP_SWEEP_SIG_EN
    m_sig   = sel ? sig_b  : sig_a;
`endif
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_x_o"},       m_x,     0);
    check({pfx, "_busy"},      m_busy,  0);
    check({pfx, "_done"},      m_done,  0);
    check({pfx, "_valid"},     m_valid, 0);
    check({pfx, "_word_data"}, m_data,  0);
    check({pfx, "_word_idx"},  m_idx,   0);
    check({pfx, "_ones_cnt"},  m_ones,  0);
  endtask

  task automatic fill_x0();
    for (int v = 0; v < 256; v++) tt[v] = v[0];
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) tt[i*32 +: 32] = $urandom();
  endtask

  // One complete sweep on the selected DUT with a fixed stall per word;
  // poke pulses start while busy, and start is also raised during FIN.
  task automatic do_sweep(input logic s, input int stall, input int lat, input logic poke);
    logic [WORD_W-1:0] exp_w [NWORDS];
    logic [WORD_W-1:0] exp_sig;
    int exp_ones, cyc, w, sc;
    logic got_done;
    sel = s;
    for (int i = 0; i < NWORDS; i++) exp_w[i] = tt[i*WORD_W +: WORD_W];
    exp_ones   = $countones(tt);
    exp_sig    = '0;
    word_ready = (stall == 0);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    cyc = 0; w = 0; sc = 0; got_done = 1'b0;
    while (!got_done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (poke && cyc == 100) set_start(1'b1);
      if (poke && cyc == 101) set_start(1'b0);
      if (cyc == 1) begin
        check("busy_after_start", m_busy, 1);
`ifdef ESOP_SWEEP_SIG_EN
        check("sig_cleared_on_start", m_sig, 0);
`endif
      end
      if (m_done) begin
        got_done = 1'b1;
      end else if (m_valid) begin
        if (w < NWORDS) begin
          check("word_idx", m_idx, w);
          check("word_data", m_data, exp_w[w]);
          if (sc >= stall) begin
            word_ready = 1'b1;
            exp_sig = {exp_sig[WORD_W-2:0], exp_sig[WORD_W-1]} ^ exp_w[w];
            w++;
            sc = 0;
          end else begin
            word_ready = 1'b0;
            sc++;
          end
        end else begin
          check("extra_word", w, NWORDS - 1);
          word_ready = 1'b1;
        end
      end else if (stall != 0) begin
        word_ready = 1'b0;
      end
    end
    check("done_seen", got_done, 1);
    check("cycles_to_done", cyc, NWORDS * (WORD_W + lat + 1 + stall));
    check("words_accepted", w, NWORDS);
    check("ones_cnt", m_ones, exp_ones);
    check("busy_in_fin", m_busy, 0);
`ifdef ESOP_SWEEP_SIG_EN
    check("sig_final", m_sig, exp_sig);
`endif
    // start during FIN must be ignored.
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    check("done_one_cycle", m_done, 0);
    check("start_in_fin_ignored", m_busy, 0);
    check("ones_cnt_held", m_ones, exp_ones);
`ifdef ESOP_SWEEP_SIG_EN
    check("sig_held", m_sig, exp_sig);
`endif
    word_ready = 1'b1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    word_ready = 1'b1; sel = 1'b0; tt = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    sel = 1'b0; check_reset_state("rst_a");
    sel = 1'b1; #1 check_reset_state("rst_b");

    // Alternating pattern, AND of all inputs, then alternating with stalls.
    fill_x0();
    do_sweep(1'b0, 0, 0, 1'b0);
    tt = '0; tt[255] = 1'b1;
    do_sweep(1'b0, 0, 0, 1'b0);
    fill_x0();
    do_sweep(1'b0, 10, 0, 1'b1);

    // Two-stage netlist latency.
    fill_x0();
    do_sweep(1'b1, 0, 2, 1'b0);
    fill_random();
    do_sweep(1'b1, 3, 2, 1'b1);

    // Reset during word 3's ISSUE phase, then a full sweep.
    sel = 1'b0;
    fill_random();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    k = 0;
    while (!(m_idx == 3 && m_busy && !m_valid) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("reached_word3", k < 1000, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    do_sweep(1'b0, 0, 0, 1'b1);

    // Randomised truth tables and stall lengths.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      do_sweep(1'b0, int'($urandom_range(0, 3)), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/esop_tt_sweeper.md
Name: esop_tt_sweeper

Overview:
- Sequential stimulus and capture stage placed directly upstream of a combinational ESOP benchmark netlist (8 inputs x0..x7, 1 output y0).
- Sweeps all 2^NIN input vectors into the netlist and samples y0 for each vector.
- Packs the samples into WORD_W-bit truth-table words and streams them out over a valid/ready interface.
- Used to extract and compare truth tables of optimized and unoptimized netlists.

Parameters:
NIN, 8, number of netlist inputs; 2^NIN vectors are swept
WORD_W, 32, truth-table word width; power of two, WORD_W <= 2^NIN
EVAL_LAT, 0, register stages inside the driven netlist (0 = purely combinational)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  begin a sweep; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final word is accepted
x_o  output  NIN  vector to netlist; bit i drives xi
y_i  input  1  netlist output y0
word_data  output  WORD_W  packed samples; bit b = result of vector (word_idx*WORD_W + b)
word_idx  output  NIN  index of the current word
word_valid  output  1  word_data/word_idx valid
word_ready  input  1  consumer accepts when word_valid & word_ready
ones_cnt  output  NIN+1  count of y_i==1 samples in the current sweep

Behaviour:
- Interface: one clock. Reset is synchronous and active-low: rst_n low at a rising edge of clk forces the reset state.
- Reset state (also the result of reset mid-sweep): IDLE; x_o=0, busy=0, done=0, word_valid=0, word_data=0, word_idx=0, ones_cnt=0. In-flight samples and the partial word are discarded.
- States: IDLE, ISSUE, DRAIN, EMIT, FIN.
- IDLE:
  - start=1 -> ISSUE.
  - Clears ones_cnt, word_idx and the vector counter vec.
- ISSUE:
  - x_o=vec; vec increments each cycle.
  - After WORD_W cycles -> DRAIN, or -> EMIT if EVAL_LAT=0.
  - x_o holds its last value outside ISSUE.
- Sampling:
  - y_i for vector v is captured at the edge ending the cycle (v presented + EVAL_LAT).
  - The sample is stored at bit v mod WORD_W.
  - ones_cnt increments on each 1 sample.
  - A delay line of sample-valid flags, EVAL_LAT deep, tracks in-flight vectors.
- DRAIN: lasts exactly EVAL_LAT cycles, then -> EMIT.
- EMIT:
  - word_valid=1. word_data and word_idx are held stable while word_ready=0.
  - On acceptance with word_idx < 2^NIN/WORD_W-1: word_idx increments, clear the word register, -> ISSUE.
  - On acceptance of the last word: -> FIN.
- FIN: done=1 for one cycle, busy=0, -> IDLE. ones_cnt holds until the next start.
- Throughput with word_ready held high: WORD_W+EVAL_LAT+1 cycles per word. NIN=8, WORD_W=32, EVAL_LAT=0 gives 264 cycles from start acceptance to done.
- start while busy: ignored.
- start in the same cycle as done: ignored (FIN is not IDLE).
- vec wraps to 0 only at sweep end; there is no wrap mid-sweep.
- ones_cnt reaches its maximum 2^NIN without overflow (NIN+1 bits).
- Backpressure never drops or duplicates a word.

Optional Feature:
- Macro: ESOP_SWEEP_SIG_EN.
- Defined:
  - Adds output port sig_o, WORD_W bits.
  - Cleared to 0 on start acceptance.
  - On each accepted word: sig_o <= rotl1(sig_o) ^ word_data.
  - Held after done; reset value 0.
- Not defined:
  - sig_o port and logic are absent.
  - All other behaviour is identical.

Test Plan:
1. Defaults, y_i tied to x_o[0], word_ready=1, pulse start -> 8 words, each word_data=0xAAAAAAAA, word_idx 0..7 in order; ones_cnt=128; done pulses exactly 264 cycles after start acceptance.
2. y_i = AND of all x_o bits -> words 0..6 = 0x00000000, word 7 = 0x80000000, ones_cnt=1.
3. Backpressure: word_ready low for 10 cycles at each EMIT -> word_data and word_idx stable while stalled; same 8 words and ones_cnt as test 1; done at 264+80 cycles.
4. EVAL_LAT=2 with a 2-stage register on x_o[0] feeding y_i -> every word 0xAAAAAAAA (no bit skew); 35 cycles per word.
5. rst_n low for 1 cycle during word 3's ISSUE -> next cycle all outputs at reset values, state IDLE. A following start gives a full, correct sweep. Start pulses during busy have no effect.
6. ESOP_SWEEP_SIG_EN defined, stimulus of test 2 -> final sig_o = 0x80000000 (only the last word is nonzero, and no rotation follows it); sig_o cleared on the next start.
